// File: rtl/hilo_div_unit_pkg.sv
// Shared definitions for the HI/LO unit: divider state encoding and HI/LO enable bit positions.
package hilo_div_unit_pkg;

  typedef enum logic [1:0] {
    DIV_IDLE = 2'd0,
    DIV_BUSY = 2'd1,
    DIV_DONE = 2'd2
  } div_state_t;

  localparam int HILO_HI = 1;
  localparam int HILO_LO = 0;

endpackage

// File: rtl/hilo_div_unit_div_radix2.sv
// Iterative restoring radix-2 divider: DATA_W+1 stall cycles, result shown for one DONE cycle.
// Flush cancels any in-flight division at the next edge.
module div_radix2
  import hilo_div_unit_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  start,
  input  logic                  is_signed,
  input  logic [DATA_W-1:0]     dividend,
  input  logic [DATA_W-1:0]     divisor,
  input  logic                  flush,
  output logic                  stall,
  output logic                  done,
  output logic [2*DATA_W-1:0]   result
);

  localparam int CNT_W = $clog2(DATA_W + 1);

  div_state_t          state, state_nxt;
  logic [DATA_W-1:0]   rem, quot, dvs;
  logic [CNT_W-1:0]    count;
  logic                neg_q, neg_r;
  logic [2*DATA_W-1:0] result_q;
  logic [2*DATA_W-1:0] fixed;
  logic                accept;
  logic [DATA_W:0]     trial;
  logic [DATA_W-1:0]   rem_step, quot_step;
  logic [DATA_W-1:0]   a_mag, b_mag;

  assign accept = (state == DIV_IDLE) & start & ~flush;
  assign a_mag  = (is_signed & dividend[DATA_W-1]) ? -dividend : dividend;
  assign b_mag  = (is_signed & divisor[DATA_W-1])  ? -divisor  : divisor;

  // Trial subtract on the partial remainder with the next dividend bit shifted in.
  assign trial = {rem, quot[DATA_W-1]} - {1'b0, dvs};

  always_comb begin
    if (!trial[DATA_W]) begin
      rem_step  = trial[DATA_W-1:0];
      quot_step = {quot[DATA_W-2:0], 1'b1};
    end else begin
      rem_step  = {rem[DATA_W-2:0], quot[DATA_W-1]};
      quot_step = {quot[DATA_W-2:0], 1'b0};
    end
  end

  assign fixed = {(neg_r ? -rem : rem), (neg_q ? -quot : quot)};

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= DIV_IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      DIV_IDLE: if (accept) state_nxt = DIV_BUSY;
      DIV_BUSY: begin
        if (flush)                       state_nxt = DIV_IDLE;
        else if (count == CNT_W'(1))     state_nxt = DIV_DONE;
      end
      DIV_DONE: state_nxt = DIV_IDLE;
      default:  state_nxt = DIV_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rem      <= '0;
      quot     <= '0;
      dvs      <= '0;
      count    <= '0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      result_q <= '0;
    end else begin
      if (accept) begin
        rem   <= '0;
        quot  <= a_mag;
        dvs   <= b_mag;
        count <= CNT_W'(DATA_W);
        neg_q <= is_signed & (dividend[DATA_W-1] ^ divisor[DATA_W-1]);
        neg_r <= is_signed & dividend[DATA_W-1];
      end else if (state == DIV_BUSY && !flush) begin
        rem   <= rem_step;
        quot  <= quot_step;
        count <= count - CNT_W'(1);
      end
      if (state == DIV_DONE) result_q <= fixed;
    end
  end

  assign stall  = accept | (state == DIV_BUSY);
  assign done   = (state == DIV_DONE);
  assign result = done ? fixed : result_q;

endmodule

// File: rtl/hilo_div_unit.sv
// HI/LO architectural register with per-half M/W forwarding, plus the E-stage divider.
// Forwarding is zero-latency; the divider stalls the pipeline DATA_W+1 cycles per divide.
module hilo_div_unit
  import hilo_div_unit_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                E_div_start,
  input  logic                E_div_signed,
  input  logic [DATA_W-1:0]   E_dividend,
  input  logic [DATA_W-1:0]   E_divisor,
  input  logic                E_flush,
  input  logic [1:0]          M_we,
  input  logic [2*DATA_W-1:0] M_hilo,
  input  logic [1:0]          W_we,
  input  logic [2*DATA_W-1:0] W_hilo,
  output logic                div_stall,
  output logic                div_done,
  output logic [2*DATA_W-1:0] div_result,
  output logic [2*DATA_W-1:0] hilo_o
);

  logic [DATA_W-1:0] hi_q, lo_q;
  logic [DATA_W-1:0] hi_fwd, lo_fwd;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      hi_q <= '0;
      lo_q <= '0;
    end else begin
      if (W_we[HILO_HI]) hi_q <= W_hilo[2*DATA_W-1:DATA_W];
      if (W_we[HILO_LO]) lo_q <= W_hilo[DATA_W-1:0];
    end
  end

  // M is younger than W, so it wins when both write the same half.
  always_comb begin
    hi_fwd = hi_q;
    lo_fwd = lo_q;
    if (M_we[HILO_HI])      hi_fwd = M_hilo[2*DATA_W-1:DATA_W];
    else if (W_we[HILO_HI]) hi_fwd = W_hilo[2*DATA_W-1:DATA_W];
    if (M_we[HILO_LO])      lo_fwd = M_hilo[DATA_W-1:0];
    else if (W_we[HILO_LO]) lo_fwd = W_hilo[DATA_W-1:0];
  end

  assign hilo_o = {hi_fwd, lo_fwd};

  div_radix2 #(.DATA_W(DATA_W)) u_div (
    .clk       (clk),
    .resetn    (resetn),
    .start     (E_div_start),
    .is_signed (E_div_signed),
    .dividend  (E_dividend),
    .divisor   (E_divisor),
    .flush     (E_flush),
    .stall     (div_stall),
    .done      (div_done),
    .result    (div_result)
  );

endmodule

// File: tb/tb_hilo_div_unit.sv
// Bench for hilo_div_unit: directed and randomized forwarding and divide checks against an arithmetic model.
module tb_hilo_div_unit;

  localparam int W = 32;

  logic          clk = 1'b0;
  logic          resetn;
  logic          E_div_start, E_div_signed, E_flush;
  logic [W-1:0]  E_dividend, E_divisor;
  logic [1:0]    M_we, W_we;
  logic [2*W-1:0] M_hilo, W_hilo;
  logic          div_stall, div_done;
  logic [2*W-1:0] div_result, hilo_o;

  int vectors = 0;
  int errors  = 0;

  logic [W-1:0]   hi_m, lo_m;
  logic [2*W-1:0] exp_hilo, last_result;

  always #5 clk = ~clk;

  hilo_div_unit #(.DATA_W(W)) dut (
    .clk          (clk),
    .resetn       (resetn),
    .E_div_start  (E_div_start),
    .E_div_signed (E_div_signed),
    .E_dividend   (E_dividend),
    .E_divisor    (E_divisor),
    .E_flush      (E_flush),
    .M_we         (M_we),
    .M_hilo       (M_hilo),
    .W_we         (W_we),
    .W_hilo       (W_hilo),
    .div_stall    (div_stall),
    .div_done     (div_done),
    .div_result   (div_result),
    .hilo_o       (hilo_o)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Architectural divide result {remainder, quotient} computed with plain integer arithmetic.
  function automatic logic [63:0] ref_div(input logic sgn, input logic [31:0] a, input logic [31:0] b);
    int sa, sb, q, r;
    if (!sgn) begin
      if (b == 0) return {a, 32'hFFFF_FFFF};
      return {a % b, a / b};
    end
    sa = a;
    sb = b;
    if (b == 0) return (sa < 0) ? {a, 32'h0000_0001} : {a, 32'hFFFF_FFFF};
    if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'h0, 32'h8000_0000};
    q = sa / sb;
    r = sa % sb;
    return {r[31:0], q[31:0]};
  endfunction

  task automatic run_div(input logic sgn, input logic [31:0] a, input logic [31:0] b, input string tag);
    logic [63:0] exp;
    int stalls;
    bit seen;
    exp    = ref_div(sgn, a, b);
    stalls = 0;
    seen   = 1'b0;
    @(negedge clk);
    E_div_start  = 1'b1;
    E_div_signed = sgn;
    E_dividend   = a;
    E_divisor    = b;
    for (int cyc = 0; cyc < 100 && !seen; cyc++) begin
      #1;
      if (div_done === 1'b1) begin
        seen = 1'b1;
        check({tag, " result"}, div_result, exp);
        check({tag, " done_cycle"}, 64'(cyc), 64'(W + 1));
        check({tag, " stall_cycles"}, 64'(stalls), 64'(W + 1));
        check({tag, " stall_in_done"}, {63'b0, div_stall}, 64'd0);
      end else begin
        if (div_stall === 1'b1) stalls++;
        @(negedge clk);
      end
    end
    check({tag, " timeout"}, {63'b0, seen}, 64'd1);
    @(posedge clk);
    #1;
    E_div_start = 1'b0;
    #1;
    check({tag, " no_restart"}, {62'b0, div_stall, div_done}, 64'd0);
    last_result = exp;
  endtask

  initial begin
    resetn = 1'b0;
    E_div_start = 1'b0; E_div_signed = 1'b0; E_flush = 1'b0;
    E_dividend = '0; E_divisor = '0;
    M_we = 2'b00; W_we = 2'b00; M_hilo = '0; W_hilo = '0;
    #12;
    check("reset hilo", hilo_o, 64'd0);
    check("reset result", div_result, 64'd0);
    check("reset stall_done", {62'b0, div_stall, div_done}, 64'd0);
    @(negedge clk);
    resetn = 1'b1;

    // Directed per-half forwarding.
    W_we = 2'b11; W_hilo = {32'hAAAA_AAAA, 32'h5555_5555};
    @(negedge clk);
    W_we = 2'b00;
    #1 check("reg_write", hilo_o, {32'hAAAA_AAAA, 32'h5555_5555});
    M_we = 2'b10; M_hilo = {32'h1, 32'hDEAD_BEEF};
    W_we = 2'b01; W_hilo = {32'hCAFE_F00D, 32'h2};
    #1 check("fwd_per_half", hilo_o, {32'h1, 32'h2});
    M_we = 2'b11; W_we = 2'b11;
    #1 check("fwd_m_priority", hilo_o, {32'h1, 32'hDEAD_BEEF});
    M_we = 2'b00; W_we = 2'b00;
    #1 check("fwd_none", hilo_o, {32'hAAAA_AAAA, 32'h5555_5555});

    // Randomized forwarding against a two-half register model.
    hi_m = 32'hAAAA_AAAA; lo_m = 32'h5555_5555;
    for (int i = 0; i < 24; i++) begin
      @(negedge clk);
      M_we = 2'($urandom); W_we = 2'($urandom);
      M_hilo = {$urandom, $urandom}; W_hilo = {$urandom, $urandom};
      exp_hilo[63:32] = M_we[1] ? M_hilo[63:32] : W_we[1] ? W_hilo[63:32] : hi_m;
      exp_hilo[31:0]  = M_we[0] ? M_hilo[31:0]  : W_we[0] ? W_hilo[31:0]  : lo_m;
      #1 check("fwd_random", hilo_o, exp_hilo);
      if (W_we[1]) hi_m = W_hilo[63:32];
      if (W_we[0]) lo_m = W_hilo[31:0];
    end
    @(negedge clk);
    M_we = 2'b00; W_we = 2'b00;
    #1 check("reg_after_random", hilo_o, {hi_m, lo_m});

    // Directed divides, back-to-back.
    run_div(1'b0, 32'd100, 32'd7, "divu_100_7");
    run_div(1'b1, 32'hFFFF_FFF9, 32'd2, "div_m7_2");
    run_div(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, "div_ovf");
    run_div(1'b0, 32'd5, 32'd0, "divu_by0");
    run_div(1'b1, 32'hFFFF_FFFB, 32'd0, "div_neg_by0");
    run_div(1'b1, 32'd7, 32'hFFFF_FFFE, "div_7_m2");
    run_div(1'b0, 32'hFFFF_FFFF, 32'd1, "divu_max_1");
    check("result_hold", div_result, last_result);

    for (int i = 0; i < 16; i++) begin
      logic [31:0] a, b;
      a = $urandom;
      b = ($urandom_range(0, 2) == 0) ? 32'($urandom_range(1, 20)) : $urandom;
      if ($urandom_range(0, 1) == 1) b = -b;
      run_div(1'($urandom), a, b, "div_random");
    end

    // Flush in BUSY cycle 10.
    @(negedge clk);
    E_div_start = 1'b1; E_div_signed = 1'b0; E_dividend = 32'd1000; E_divisor = 32'd3;
    for (int k = 0; k < 10; k++) @(negedge clk);
    E_flush = 1'b1; E_div_start = 1'b0;
    #1 check("flush_stall_busy", {63'b0, div_stall}, 64'd1);
    @(negedge clk);
    E_flush = 1'b0;
    #1 check("flush_idle", {62'b0, div_stall, div_done}, 64'd0);
    begin
      int pulses;
      pulses = 0;
      for (int k = 0; k < 40; k++) begin
        @(negedge clk);
        #1 if (div_done === 1'b1) pulses++;
      end
      check("flush_no_done", 64'(pulses), 64'd0);
    end
    check("flush_result_hold", div_result, last_result);
    run_div(1'b0, 32'd1000, 32'd3, "after_flush");

    // Asynchronous reset mid-BUSY.
    @(negedge clk);
    W_we = 2'b11; W_hilo = {32'h1234_5678, 32'h9ABC_DEF0};
    E_div_start = 1'b1; E_div_signed = 1'b1; E_dividend = 32'd77; E_divisor = 32'd5;
    @(negedge clk);
    W_we = 2'b00;
    for (int k = 0; k < 5; k++) @(negedge clk);
    #1 check("pre_reset_stall", {63'b0, div_stall}, 64'd1);
    resetn = 1'b0; E_div_start = 1'b0;
    #1;
    check("midreset_stall_done", {62'b0, div_stall, div_done}, 64'd0);
    check("midreset_hilo", hilo_o, 64'd0);
    check("midreset_result", div_result, 64'd0);
    @(negedge clk);
    resetn = 1'b1;
    W_we = 2'b11; W_hilo = 64'h1_0000_0002;
    @(negedge clk);
    W_we = 2'b00;
    #1 check("post_reset_write", hilo_o, 64'h1_0000_0002);
    run_div(1'b0, 32'd100, 32'd7, "post_reset_div");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
